// File: rtl/tt_cpu_pkg.sv
// Shared constants for the tiny-CPU tile: bus widths, opcodes and the program-memory
// responder's mode encoding, plus the reset-time demo program.
package tt_cpu_pkg;

  localparam int DATA_W = 6;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  localparam logic [DATA_W-1:0] OP_ADD       = 6'd1;
  localparam logic [DATA_W-1:0] OP_SWAP      = 6'd2;
  localparam logic [DATA_W-1:0] OP_JMP       = 6'd3;
  localparam logic [DATA_W-1:0] OP_JZ        = 6'd4;
  localparam logic [DATA_W-1:0] PRELOAD_FILL = 6'h3C;

  typedef enum logic {
    SERVE = 1'b0,
    LOAD  = 1'b1
  } state_e;

  // Demo program: add, swap, jz 0, jmp 4; the rest is filler.
  function automatic logic [DATA_W-1:0] preload_word(input int unsigned idx);
    case (idx)
      0:       preload_word = OP_ADD;
      1:       preload_word = OP_SWAP;
      2:       preload_word = OP_JZ;
      3:       preload_word = 6'd0;
      4:       preload_word = OP_JMP;
      5:       preload_word = 6'd4;
      default: preload_word = PRELOAD_FILL;
    endcase
  endfunction

endpackage

// File: rtl/tt_serial_word_loader.sv
// Serial-to-parallel word assembler: shifts bits in MSB first and pulses commit
// on the cycle carrying the last bit, presenting the finished word alongside it.
module tt_serial_word_loader #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] word,
  output logic              commit
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-2:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Word is complete combinationally so the commit edge writes it directly.
  assign word   = {shift_q, bit_in};
  assign commit = shift_en && (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = word[DATA_W-2:0];
      cnt_d   = commit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/tt_prog_mem_responder.sv
// Program memory beside the tiny CPU: zero-latency reads in SERVE, serial
// reload of the whole array in LOAD, demo program restored on reset.
module tt_prog_mem_responder #(
  parameter int DATA_W = tt_cpu_pkg::DATA_W,
  parameter int ADDR_W = tt_cpu_pkg::ADDR_W,
  parameter int DEPTH  = tt_cpu_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic              load_bit,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count
);

  import tt_cpu_pkg::*;

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              in_load;
  logic              shift_en;
  logic              loader_clear;
  logic              commit;
  logic [DATA_W-1:0] word;

  assign in_load = (state_q == LOAD);
  // The entry edge and the exit edge never shift; a dropped load_en discards the partial word.
  assign shift_en     = in_load && load_en && load_valid;
  assign loader_clear = !(in_load && load_en);

  tt_serial_word_loader #(
    .DATA_W (DATA_W)
  ) u_loader (
    .clk      (clk),
    .reset    (reset),
    .clear    (loader_clear),
    .shift_en (shift_en),
    .bit_in   (load_bit),
    .word     (word),
    .commit   (commit)
  );

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    load_count_d = load_count_q;
    mem_d        = mem_q;
    case (state_q)
      SERVE: begin
        if (load_en) begin
          state_d      = LOAD;
          wptr_d       = '0;
          load_count_d = '0;
        end
      end
      LOAD: begin
        if (!load_en) begin
          state_d = SERVE;
        end else if (commit) begin
          mem_d[wptr_q] = word;
          wptr_d        = wptr_q + ADDR_W'(1);
          if (load_count_q != CNT_MAX) load_count_d = load_count_q + (ADDR_W + 1)'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SERVE;
      wptr_q       <= '0;
      load_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(preload_word(i));
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      load_count_q <= load_count_d;
      mem_q        <= mem_d;
    end
  end

  assign data       = in_load ? '0 : mem_q[addr];
  assign load_busy  = in_load;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_tt_prog_mem_responder.sv
// Directed-plus-random bench for tt_prog_mem_responder against a word-level model
// of the program store (array, write pointer, saturating word count).
module tb_tt_prog_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] addr;
  logic [5:0] data;
  logic       load_en;
  logic       load_valid;
  logic       load_bit;
  logic       load_busy;
  logic [6:0] load_count;

  int checks   = 0;
  int failures = 0;

  logic [5:0] model_mem [64];
  int         model_wp;
  int         model_cnt;

  tt_prog_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .data       (data),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_bit   (load_bit),
    .load_busy  (load_busy),
    .load_count (load_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are always driven just after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_preload();
    logic [5:0] prog [6];
    prog = '{6'd1, 6'd2, 6'd4, 6'd0, 6'd3, 6'd4};
    for (int i = 0; i < 64; i++) model_mem[i] = (i < 6) ? prog[i] : 6'h3C;
    model_wp  = 0;
    model_cnt = 0;
  endtask

  task automatic peek(input string tag, input int a);
    addr = 6'(a);
    #1;
    chk(tag, 32'(data), 32'(model_mem[a]));
    tick();
  endtask

  task automatic enter_load();
    load_en = 1'b1;
    tick();
    model_wp  = 0;
    model_cnt = 0;
  endtask

  task automatic exit_load();
    load_en = 1'b0;
    tick();
  endtask

  task automatic load_word(input logic [5:0] w, input int gap);
    for (int i = 5; i >= 0; i--) begin
      repeat (gap) begin
        load_valid = 1'b0;
        load_bit   = 1'($urandom);
        tick();
      end
      load_bit   = w[i];
      load_valid = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    model_mem[model_wp] = w;
    model_wp = (model_wp + 1) % 64;
    if (model_cnt < 64) model_cnt++;
  endtask

  initial begin
    logic [5:0] w;
    int         a;

    reset      = 1'b1;
    addr       = 6'd0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    load_bit   = 1'b0;
    model_preload();
    #1;
    chk("reset_data_addr0", 32'(data), 32'd1);
    chk("reset_busy", 32'(load_busy), 32'd0);
    chk("reset_count", 32'(load_count), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Preloaded program sweep plus random reads.
    for (int i = 0; i < 8; i++) peek($sformatf("preload_a%0d", i), i);
    chk("serve_busy", 32'(load_busy), 32'd0);
    repeat (6) begin
      a = int'($urandom_range(63, 0));
      peek($sformatf("preload_rand_a%0d", a), a);
    end

    // Two words, data forced to zero while loading.
    enter_load();
    chk("load_busy_entry", 32'(load_busy), 32'd1);
    chk("load_count_entry", 32'(load_count), 32'd0);
    addr = 6'($urandom_range(63, 0));
    #1;
    chk("load_data_zero", 32'(data), 32'd0);
    load_word(6'b101010, 0);
    load_word(6'b000111, 0);
    chk("load_count_two", 32'(load_count), 32'(model_cnt));
    exit_load();
    chk("exit_busy", 32'(load_busy), 32'd0);
    peek("two_words_a0", 0);
    peek("two_words_a1", 1);
    peek("two_words_a2", 2);
    chk("two_words_a0_const", 32'(model_mem[0]), 32'h2A);

    // Partial word abandoned, then restart from address 0 with a clean bit count.
    enter_load();
    for (int i = 0; i < 3; i++) begin
      load_bit   = 1'b1;
      load_valid = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    exit_load();
    peek("partial_no_write_a0", 0);
    peek("partial_no_write_a2", 2);
    enter_load();
    chk("reenter_count", 32'(load_count), 32'd0);
    w = 6'($urandom);
    for (int i = 5; i >= 1; i--) begin
      load_bit   = w[i];
      load_valid = 1'b1;
      tick();
    end
    chk("reenter_no_early_commit", 32'(load_count), 32'd0);
    load_bit = w[0];
    tick();
    load_valid = 1'b0;
    model_mem[0] = w;
    model_wp  = 1;
    model_cnt = 1;
    chk("reenter_one_commit", 32'(load_count), 32'd1);
    exit_load();
    peek("reenter_word_a0", 0);
    peek("reenter_untouched_a1", 1);

    // 65 words: address 0 wraps over, count saturates.
    enter_load();
    for (int k = 0; k < 64; k++) load_word(6'(k), 0);
    chk("full_count_64", 32'(load_count), 32'd64);
    load_word(6'h15, 0);
    chk("wrap_count_sat", 32'(load_count), 32'd64);
    exit_load();
    peek("wrap_a0", 0);
    peek("wrap_a1", 1);
    peek("wrap_a63", 63);
    repeat (4) begin
      a = int'($urandom_range(63, 0));
      peek($sformatf("wrap_rand_a%0d", a), a);
    end

    // Sparse valids (one bit every third cycle) and random gaps.
    enter_load();
    load_word(6'h3F, 2);
    chk("gap_count", 32'(load_count), 32'd1);
    repeat (8) load_word(6'($urandom), int'($urandom_range(2, 0)));
    chk("rand_count", 32'(load_count), 32'(model_cnt));
    exit_load();
    for (int i = 0; i < 10; i++) peek($sformatf("rand_load_a%0d", i), i);

    // load_valid outside load mode changes nothing.
    for (int i = 0; i < 12; i++) begin
      load_valid = 1'b1;
      load_bit   = 1'($urandom);
      tick();
    end
    load_valid = 1'b0;
    chk("ignored_busy", 32'(load_busy), 32'd0);
    chk("ignored_count", 32'(load_count), 32'(model_cnt));
    for (int i = 0; i < 3; i++) peek($sformatf("ignored_a%0d", i), i);

    // Asynchronous reset in the middle of a word.
    enter_load();
    load_word(6'($urandom), 0);
    load_word(6'($urandom), 0);
    for (int i = 0; i < 3; i++) begin
      load_bit   = 1'($urandom);
      load_valid = 1'b1;
      tick();
    end
    addr = 6'd0;
    #1;
    reset      = 1'b1;
    load_en    = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("async_reset_busy", 32'(load_busy), 32'd0);
    chk("async_reset_count", 32'(load_count), 32'd0);
    chk("async_reset_data", 32'(data), 32'd1);
    tick();
    reset = 1'b0;
    model_preload();
    tick();
    peek("post_reset_a0", 0);
    peek("post_reset_a1", 1);
    peek("post_reset_a6", 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
